// File: rtl/bcd_para_binario_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   - FSM state encoding (OCIOSO, CONVERTE, FIM)
//   - Digit constants used by the per-digit correction stage
package bcd_para_binario_pkg;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] FIM      = 2'd2;

  typedef enum logic [1:0] {
    StOcioso   = OCIOSO,
    StConverte = CONVERTE,
    StFim      = FIM
  } estado_e;

  localparam logic [3:0] BCD_MAX_DIGITO = 4'd9;
  localparam logic [3:0] BCD_AJUSTE     = 4'd3;
  localparam logic [3:0] BCD_LIMIAR     = 4'd8;

endpackage

// File: rtl/bcd_para_binario_ajuste.sv
// Combinational per-digit stage of the reverse double-dabble.
//   digito_i   : 4-bit BCD digit
//   digito_o   : digito_i - 3 when digito_i >= 8, else digito_i
//   invalido_o : digito_i is not a legal BCD digit (> 9)
module bcd_ajuste_digito
  import bcd_para_binario_pkg::*;
(
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o,
  output logic       invalido_o
);

  always_comb begin
    digito_o   = (digito_i >= BCD_LIMIAR) ? (digito_i - BCD_AJUSTE) : digito_i;
    invalido_o = (digito_i > BCD_MAX_DIGITO);
  end

endmodule

// File: rtl/bcd_para_binario.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   inicio   : start request, sampled only while idle
//   bcd      : packed BCD digits, bcd[3:0] = unidade
//   negativo : (BCD_SIGN_EN only) sign captured with bcd; result is negated
//   numero   : binary result, held until the next completion
//   ocupado  : conversion in progress
//   pronto   : one-cycle pulse when numero/erro are updated
//   erro     : captured input had a digit > 9 (numero forced to 0)
// Optional feature: define BCD_SIGN_EN to add the negativo input.
module bcd_para_binario
  import bcd_para_binario_pkg::*;
#(
  parameter int unsigned DIGITOS = 2,
  parameter int unsigned LARGURA = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   inicio,
`ifdef BCD_SIGN_EN
  input  logic                   negativo,
`endif
  input  logic [4*DIGITOS-1:0]   bcd,
  output logic [LARGURA-1:0]     numero,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   erro
);

  localparam int unsigned W  = 4 * DIGITOS;
  localparam int unsigned CW = $clog2(W + 1);

  estado_e              estado_q, estado_d;
  logic [W-1:0]         b_q, b_d;
  logic [W-1:0]         a_q, a_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic                 erro_pend_q, erro_pend_d;
  logic [LARGURA-1:0]   numero_q, numero_d;
  logic                 pronto_q, pronto_d;
  logic                 erro_q, erro_d;
`ifdef BCD_SIGN_EN
  logic                 neg_q, neg_d;
`endif

  logic [W-1:0]         b_desl, a_desl;
  logic [W-1:0]         dig_in, b_aj;
  logic [DIGITOS-1:0]   invalido;
  logic [LARGURA-1:0]   resultado;

  always_comb begin
    b_desl = b_q >> 1;
    a_desl = {b_q[0], a_q[W-1:1]};
    // The digit stages are shared: while idle they only validate the incoming
    // digits, while converting they correct the freshly shifted B.
    dig_in    = (estado_q == StOcioso) ? bcd : b_desl;
    resultado = LARGURA'(a_q);
  end

  for (genvar g = 0; g < DIGITOS; g++) begin : g_digito
    bcd_ajuste_digito u_ajuste (
      .digito_i   (dig_in[4*g +: 4]),
      .digito_o   (b_aj[4*g +: 4]),
      .invalido_o (invalido[g])
    );
  end

  always_comb begin
    estado_d    = estado_q;
    b_d         = b_q;
    a_d         = a_q;
    cont_d      = cont_q;
    erro_pend_d = erro_pend_q;
    numero_d    = numero_q;
    pronto_d    = 1'b0;
    erro_d      = erro_q;
`ifdef BCD_SIGN_EN
    neg_d       = neg_q;
`endif
    unique case (estado_q)
      StOcioso: begin
        if (inicio) begin
          b_d = bcd;
          a_d = '0;
`ifdef BCD_SIGN_EN
          neg_d = negativo;
`endif
          if (|invalido) begin
            erro_pend_d = 1'b1;
            estado_d    = StFim;
          end else begin
            erro_pend_d = 1'b0;
            cont_d      = CW'(W);
            estado_d    = StConverte;
          end
        end
      end
      StConverte: begin
        b_d    = b_aj;
        a_d    = a_desl;
        cont_d = cont_q - 1'b1;
        if (cont_q == CW'(1)) begin
          estado_d = StFim;
        end
      end
      StFim: begin
        pronto_d = 1'b1;
        erro_d   = erro_pend_q;
        if (erro_pend_q) begin
          numero_d = '0;
        end else begin
`ifdef BCD_SIGN_EN
          numero_d = neg_q ? (LARGURA'(0) - resultado) : resultado;
`else
          numero_d = resultado;
`endif
        end
        estado_d = StOcioso;
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= StOcioso;
      b_q         <= '0;
      a_q         <= '0;
      cont_q      <= '0;
      erro_pend_q <= 1'b0;
      numero_q    <= '0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
`ifdef BCD_SIGN_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      b_q         <= b_d;
      a_q         <= a_d;
      cont_q      <= cont_d;
      erro_pend_q <= erro_pend_d;
      numero_q    <= numero_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
`ifdef BCD_SIGN_EN
      neg_q       <= neg_d;
`endif
    end
  end

  always_comb begin
    numero  = numero_q;
    pronto  = pronto_q;
    erro    = erro_q;
    ocupado = (estado_q != StOcioso);
  end

endmodule

// File: tb/tb_bcd_para_binario.sv
// Self-checking bench for bcd_para_binario (DIGITOS=2 scoreboarded, DIGITOS=4 direct).
module tb_bcd_para_binario;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        inicio = 1'b0;
  logic        negativo = 1'b0;
  logic [7:0]  bcd = 8'h00;
  logic [31:0] numero;
  logic        ocupado, pronto, erro;

  logic        inicio4 = 1'b0;
  logic [15:0] bcd4 = 16'h0000;
  logic [31:0] numero4;
  logic        ocupado4, pronto4, erro4;

  int cyc = 0;
  int testes = 0;
  int falhas = 0;

  typedef struct {
    logic [31:0] numero;
    logic        erro;
    int          ciclo;
  } esp_t;

  esp_t fila[$];

  bcd_para_binario #(.DIGITOS(2), .LARGURA(32)) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .inicio   (inicio),
`ifdef BCD_SIGN_EN
    .negativo (negativo),
`endif
    .bcd      (bcd),
    .numero   (numero),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .erro     (erro)
  );

  bcd_para_binario #(.DIGITOS(4), .LARGURA(32)) u_dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .inicio   (inicio4),
`ifdef BCD_SIGN_EN
    .negativo (negativo),
`endif
    .bcd      (bcd4),
    .numero   (numero4),
    .ocupado  (ocupado4),
    .pronto   (pronto4),
    .erro     (erro4)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic verificar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: obtido %0h, esperado %0h", tag, obs, esp);
    end
  endtask

  function automatic logic bcd_invalido(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  function automatic logic [31:0] modelo(input logic [7:0] v, input logic neg);
    logic [31:0] mag;
    mag = 32'(v[7:4]) * 32'd10 + 32'(v[3:0]);
    if (bcd_invalido(v)) return 32'd0;
`ifdef BCD_SIGN_EN
    if (neg) return 32'd0 - mag;
`endif
    return mag;
  endfunction

  // Scoreboard: every pronto must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && pronto) begin
      if (fila.size() == 0) begin
        verificar("pronto_espurio", 64'(pronto), 64'd0);
      end else begin
        esp_t e;
        e = fila.pop_front();
        verificar("numero", 64'(numero), 64'(e.numero));
        verificar("erro", 64'(erro), 64'(e.erro));
        verificar("latencia", 64'(cyc), 64'(e.ciclo));
      end
    end
  end

  task automatic converter(input logic [7:0] v, input logic neg);
    esp_t e;
    int   occ;
    logic inv;
    inv = bcd_invalido(v);
    @(negedge clock);
    bcd      = v;
    negativo = neg;
    inicio   = 1'b1;
    e.numero = modelo(v, neg);
    e.erro   = inv;
    e.ciclo  = cyc + 1 + (inv ? 1 : 9);
    fila.push_back(e);
    @(negedge clock);
    inicio   = 1'b0;
    bcd      = ~v;
    negativo = ~neg;
    occ = 0;
    for (int i = 0; i < 9; i++) begin
      occ += int'(ocupado);
      @(negedge clock);
    end
    verificar("ocupado_ciclos", 64'(occ), inv ? 64'd1 : 64'd9);
    repeat (3) @(negedge clock);
  endtask

  task automatic converter4(input logic [15:0] v, input logic [31:0] esp);
    int t0;
    int lat;
    @(negedge clock);
    bcd4    = v;
    inicio4 = 1'b1;
    t0      = cyc + 1;
    @(negedge clock);
    inicio4 = 1'b0;
    bcd4    = 16'hFFFF;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (pronto4) lat = cyc - t0;
      else @(negedge clock);
    end
    verificar("lat4", 64'(lat), 64'd17);
    verificar("numero4", 64'(numero4), 64'(esp));
    verificar("erro4", 64'(erro4), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  logic [7:0] tabela [6] = '{8'h99, 8'h3A, 8'h12, 8'h58, 8'hA0, 8'h07};

  initial begin
    repeat (2) @(negedge clock);
    verificar("reset_numero", 64'(numero), 64'd0);
    verificar("reset_ocupado", 64'(ocupado), 64'd0);
    verificar("reset_pronto", 64'(pronto), 64'd0);
    verificar("reset_erro", 64'(erro), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    foreach (tabela[i]) converter(tabela[i], 1'b0);

    // Back-to-back with inicio held high: 00 accepted first, 47 on the first idle cycle.
    begin
      esp_t e;
      @(negedge clock);
      bcd    = 8'h00;
      inicio = 1'b1;
      e.numero = 32'd0;  e.erro = 1'b0; e.ciclo = cyc + 1 + 9;
      fila.push_back(e);
      e.numero = 32'd47; e.erro = 1'b0; e.ciclo = cyc + 1 + 19;
      fila.push_back(e);
      @(negedge clock);
      bcd = 8'h47;
      repeat (11) @(negedge clock);
      inicio = 1'b0;
      bcd    = 8'h00;
      repeat (12) @(negedge clock);
    end

`ifdef BCD_SIGN_EN
    converter(8'h05, 1'b1);
    converter(8'h00, 1'b1);
`endif

    // Reset in the middle of a conversion: outputs clear at once, no pronto follows.
    converter(8'h99, 1'b0);
    @(negedge clock);
    bcd    = 8'h55;
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    verificar("abort_numero", 64'(numero), 64'd0);
    verificar("abort_ocupado", 64'(ocupado), 64'd0);
    verificar("abort_pronto", 64'(pronto), 64'd0);
    verificar("abort_erro", 64'(erro), 64'd0);
    verificar("abort_ocupado4", 64'(ocupado4), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);

    converter4(16'h9999, 32'd9999);
    converter4(16'h1234, 32'd1234);

    for (int i = 0; i < 50 && fila.size() != 0; i++) @(negedge clock);
    verificar("fila_pendente", 64'(fila.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
